// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter with one-deep pending sample buffer, 64-bclk frames, left-justified MSB one bclk after lrck edge.
// Ports: AUDIO_CLK clock; reset_data sync active-high reset; lsound_in/rsound_in samples latched on sample_valid;
// bclk/lrck/sdata I2S outputs; frame_start, underrun, overrun single-cycle status pulses.
module audio_i2s_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int BCLK_DIV = 4
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_data,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     bclk,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     frame_start,
    output logic                     underrun,
    output logic                     overrun
);
    localparam int DW = $clog2(BCLK_DIV);
    logic [DW-1:0] div_cnt;
    logic [5:0] bit_cnt, s;
    logic [4:0] k, idx;
    logic [AUD_BIT_DEPTH-1:0] frame_l, frame_r, pend_l, pend_r, word;
    logic pend_valid, tick, fe, load, bit_next;
    always_comb begin
        tick = div_cnt == DW'(BCLK_DIV - 1);
        fe = tick && bclk;
        s = bit_cnt + 6'd1;
        load = fe && s == 6'd0;
        k = s[4:0];
        idx = 5'(AUD_BIT_DEPTH) - k;
        word = s[5] ? frame_r : frame_l;
        // slot positions 1..AUD_BIT_DEPTH carry the word MSB first; the rest is zero padding
        bit_next = (k != 5'd0 && k <= 5'(AUD_BIT_DEPTH)) ? word[idx] : 1'b0;
    end
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            div_cnt <= '0;
            bclk <= 1'b0;
            bit_cnt <= 6'd63;
            lrck <= 1'b1;
            sdata <= 1'b0;
            frame_l <= '0;
            frame_r <= '0;
            pend_l <= '0;
            pend_r <= '0;
            pend_valid <= 1'b0;
            frame_start <= 1'b0;
            underrun <= 1'b0;
            overrun <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) bclk <= ~bclk;
            frame_start <= load;
            underrun <= load && !pend_valid;
            overrun <= sample_valid && pend_valid && !load;
            if (fe) begin
                bit_cnt <= s;
                lrck <= s[5];
                sdata <= bit_next;
            end
            // a load always consumes the pre-cycle pending contents; a coincident strobe refills pending
            if (load && pend_valid) begin
                frame_l <= pend_l;
                frame_r <= pend_r;
            end
            if (sample_valid) begin
                pend_l <= lsound_in;
                pend_r <= rsound_in;
            end
            pend_valid <= sample_valid || (pend_valid && !load);
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed self-checking bench for audio_i2s_tx with BCLK_DIV=2, AUD_BIT_DEPTH=24.
module tb_audio_i2s_tx;
    logic clk = 1'b0;
    logic reset_data = 1'b1;
    logic [23:0] lsound_in = '0;
    logic [23:0] rsound_in = '0;
    logic sample_valid = 1'b0;
    logic bclk, lrck, sdata, frame_start, underrun, overrun;
    int checks = 0;
    int failures = 0;
    int ov_cnt = 0;
    int n, len, ov0, s;
    logic pb, ur;
    logic [63:0] sd, lr;
    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] SD_030 = 64'h00FF_FFFC_0100_0002;

    audio_i2s_tx #(.AUD_BIT_DEPTH(24), .BCLK_DIV(2)) dut (
        .AUDIO_CLK(clk),
        .reset_data(reset_data),
        .lsound_in(lsound_in),
        .rsound_in(rsound_in),
        .sample_valid(sample_valid),
        .bclk(bclk),
        .lrck(lrck),
        .sdata(sdata),
        .frame_start(frame_start),
        .underrun(underrun),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun === 1'b1) ov_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] e;
        e = '0;
        for (int i = 1; i <= 24; i++) begin
            e[i] = l[24-i];
            e[32+i] = r[24-i];
        end
        return e;
    endfunction

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (frame_start !== 1'b1 && cyc < 1000);
    endtask

    task automatic frame(input int inj1, input logic [23:0] l1, input logic [23:0] r1,
                         input int inj2, input logic [23:0] l2, input logic [23:0] r2,
                         output logic [63:0] fsd, output logic [63:0] flr,
                         output int flen, output logic fur);
        int c;
        int bi;
        logic p;
        c = 0;
        bi = 0;
        fsd = '0;
        flr = '0;
        fsd[0] = sdata;
        flr[0] = lrck;
        p = bclk;
        do begin
            @(negedge clk);
            c++;
            sample_valid = (c == inj1) || (c == inj2);
            if (c == inj1) begin lsound_in = l1; rsound_in = r1; end
            if (c == inj2) begin lsound_in = l2; rsound_in = r2; end
            if (p && !bclk && frame_start !== 1'b1) begin
                bi++;
                if (bi < 64) begin
                    fsd[bi] = sdata;
                    flr[bi] = lrck;
                end
            end
            p = bclk;
        end while (frame_start !== 1'b1 && c < 1000);
        flen = c;
        fur = underrun;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bclk", bclk, 0);
        chk("rst_lrck", lrck, 1);
        chk("rst_sdata", sdata, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        reset_data = 1'b0;
        wait_start(n);
        chk("first_fe_latency", n, 4);
        chk("first_underrun", underrun, 1);
        // F1: zeros from reset; sample for next frame arrives mid-frame
        frame(100, 24'h800001, 24'h7FFFFE, -1, '0, '0, sd, lr, len, ur);
        chk("f1_sdata_zero", sd, 0);
        chk("f1_lrck", lr, LR_EXP);
        chk("f1_len", len, 256);
        chk("f2_underrun", ur, 0);
        // F2: carries the sample
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("f2_sdata", sd, SD_030);
        chk("f2_lrck", lr, LR_EXP);
        chk("f2_len", len, 256);
        chk("f3_underrun", ur, 1);
        chk("f2_no_overrun", ov_cnt, 0);
        // F3: repeat of F2; A then B arrive, B overwrites A
        ov0 = ov_cnt;
        frame(20, 24'h123456, 24'h654321, 120, 24'hABCDEF, 24'h13579B, sd, lr, len, ur);
        chk("f3_repeat", sd, SD_030);
        chk("f3_overrun_once", ov_cnt - ov0, 1);
        chk("f4_underrun", ur, 0);
        // F4 carries B; F5 and F6 repeat it with underrun
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("f4_sdata_b", sd, exp_sd(24'hABCDEF, 24'h13579B));
        chk("f5_underrun", ur, 1);
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("f5_repeat_b", sd, exp_sd(24'hABCDEF, 24'h13579B));
        chk("f6_underrun", ur, 1);
        // F6: strobe lands exactly in the load cycle with nothing pending
        ov0 = ov_cnt;
        frame(255, 24'hC3A501, 24'h00F00F, -1, '0, '0, sd, lr, len, ur);
        chk("f6_repeat_b", sd, exp_sd(24'hABCDEF, 24'h13579B));
        chk("f7_underrun_coincide", ur, 1);
        chk("f7_no_overrun_coincide", overrun, 0);
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("f7_repeat_b", sd, exp_sd(24'hABCDEF, 24'h13579B));
        chk("f8_underrun", ur, 0);
        chk("coincide_no_overrun", ov_cnt - ov0, 0);
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("f8_sdata_c", sd, exp_sd(24'hC3A501, 24'h00F00F));
        chk("f8_len", len, 256);
        // mid-frame reset at bit 40 with a pending sample that must be discarded
        s = 0;
        n = 0;
        pb = bclk;
        do begin
            @(negedge clk);
            n++;
            sample_valid = 1'b0;
            if (pb && !bclk) begin
                s++;
                if (s == 38) begin
                    sample_valid = 1'b1;
                    lsound_in = 24'hFFFFFF;
                    rsound_in = 24'hFFFFFF;
                end
            end
            pb = bclk;
        end while (s < 40 && n < 1000);
        chk("mid_lrck_at_40", lrck, 1);
        reset_data = 1'b1;
        @(negedge clk);
        chk("mid_rst_bclk", bclk, 0);
        chk("mid_rst_lrck", lrck, 1);
        chk("mid_rst_sdata", sdata, 0);
        chk("mid_rst_pulses", {frame_start, underrun, overrun}, 0);
        @(negedge clk);
        reset_data = 1'b0;
        wait_start(n);
        chk("restart_latency", n, 4);
        chk("restart_underrun", underrun, 1);
        frame(-1, '0, '0, -1, '0, '0, sd, lr, len, ur);
        chk("restart_sdata_zero", sd, 0);
        chk("restart_len", len, 256);
        chk("restart_next_underrun", ur, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter AUD_BIT_DEPTH, default 24: width of each audio sample word; legal range 16..31.
REQ-002 Parameter BCLK_DIV, default 4: AUDIO_CLK cycles per bclk half-period; legal range >=2.
REQ-003 Port AUDIO_CLK, input, 1: the only clock; all logic on its rising edge.
REQ-004 Port reset_data, input, 1: synchronous, active-high reset.
REQ-005 Port lsound_in, input, AUD_BIT_DEPTH: left sample, two's complement, from the synthesizer's lsound_out.
REQ-006 Port rsound_in, input, AUD_BIT_DEPTH: right sample, two's complement, from the synthesizer's rsound_out.
REQ-007 Port sample_valid, input, 1: one-cycle strobe; lsound_in and rsound_in are valid in this cycle.
REQ-008 Port bclk, output, 1: I2S bit clock.
REQ-009 Port lrck, output, 1: I2S word select; 0 = left, 1 = right.
REQ-010 Port sdata, output, 1: I2S serial data, MSB first.
REQ-011 Port frame_start, output, 1: one-cycle pulse when a new frame is loaded.
REQ-012 Port underrun, output, 1: one-cycle pulse when a frame is loaded with no pending sample.
REQ-013 Port overrun, output, 1: one-cycle pulse when a pending sample is overwritten before use.

Function
REQ-014 div_cnt SHALL count 0..BCLK_DIV-1 and wrap; bclk SHALL toggle in the cycle div_cnt==BCLK_DIV-1. The bclk period is therefore 2*BCLK_DIV clocks.
REQ-015 A falling-edge event (FE) SHALL be the cycle in which bclk toggles from 1 to 0. All of bit_cnt, lrck, sdata and the frame load SHALL update only on FE.
REQ-016 bit_cnt (6 bits) SHALL increment by 1 on each FE and wrap 63->0. A frame is 64 bclk periods: two 32-bit slots.
REQ-017 On FE, with s the new bit_cnt value, lrck SHALL be set to (s>=32).
REQ-018 On FE, sdata SHALL be set as follows:
- left-word bit (AUD_BIT_DEPTH-s) for s in 1..AUD_BIT_DEPTH;
- right-word bit (AUD_BIT_DEPTH-(s-32)) for s in 33..32+AUD_BIT_DEPTH;
- 0 otherwise.
This gives the MSB one bclk after each lrck transition, left-justified and zero-padded.
REQ-019 A pending register (pend_l, pend_r, pend_valid) SHALL capture lsound_in and rsound_in and set pend_valid on every sample_valid.
REQ-020 On the FE where s becomes 0, the frame register SHALL be loaded before driving the s=0 bit:
- if pend_valid=1: load from pend_l/pend_r, clear pend_valid;
- if pend_valid=0: keep the previous frame contents and pulse underrun.
REQ-021 frame_start SHALL pulse in every cycle in which REQ-020 executes.
REQ-022 If sample_valid arrives while pend_valid=1 and no frame load occurs in the same cycle, the pending data SHALL be overwritten, pend_valid SHALL stay 1, and overrun SHALL pulse.
REQ-023 If sample_valid coincides with a frame load:
- the frame SHALL take the old pending contents (repeat path if pend_valid was 0);
- the new sample SHALL go into pending with pend_valid=1;
- no overrun SHALL be signalled;
- underrun SHALL follow REQ-020 using the pre-cycle pend_valid.
REQ-024 underrun, overrun and frame_start SHALL be registered single-cycle pulses with no latching.
REQ-025 The minimum sample_valid-to-MSB latency is 1 FE (frame load) plus 1 bclk period; the maximum is one frame plus 1 bclk period.

Reset
REQ-026 While reset_data=1, the block SHALL hold:
- div_cnt=0, bclk=0, bit_cnt=63, lrck=1, sdata=0;
- frame registers=0, pend_valid=0, pend_l=pend_r=0;
- frame_start=underrun=overrun=0.
REQ-027 After reset deasserts, the first FE SHALL occur 2*BCLK_DIV cycles later. It SHALL move bit_cnt to 0 and execute REQ-020; with no prior sample this pulses underrun and sends zeros.
REQ-028 Reset asserted mid-frame SHALL abort serialization immediately and discard any pending sample.

Verification
REQ-029 BCLK_DIV=2, reset released -> bclk period 4 clocks, frame_start every 256 clocks, first frame underrun=1, sdata=0 throughout.
REQ-030 One sample_valid with L=0x800001, R=0x7FFFFE before a frame boundary -> left slot bits 1..24 = 1000...0001, right slot bits 33..56 = 0111...1110, lrck low for slots 0..31, no underrun.
REQ-031 Two sample_valid strobes (A then B) within one frame -> overrun pulses once, next frame carries B.
REQ-032 No sample_valid for 2 frames after a loaded frame -> the frame repeats twice, underrun pulses at each frame_start.
REQ-033 sample_valid in exactly the frame-load cycle with pend_valid=0 -> underrun=1, overrun=0, the following frame carries the new sample.
REQ-034 reset_data pulsed at bit_cnt=40 -> the next cycle shows the REQ-026 values, and the restart matches REQ-029.
